// File: rtl/psram_arbiter.sv
// psram_arbiter: PSRAM access arbiter/sequencer for the 16-bit ROM bus.
// SNES bus cycles have absolute priority; NCH secondary channels are served
// through a level request / one-cycle acknowledge handshake.
// Optional macro PSRAM_ARB_RR_EN: round-robin channel grant instead of
// fixed lowest-index priority.
module psram_arbiter #(
    parameter int NCH          = 2,
    parameter int ADDR_W       = 24,
    parameter int SNES_RD_WAIT = 4,
    parameter int SNES_WR_WAIT = 5,
    parameter int CH_RD_WAIT   = 6,
    parameter int CH_WR_WAIT   = 6
) (
    input  logic                  CLK2,
    input  logic                  RST_N,
    input  logic                  SNES_CYCLE_START,
    input  logic                  SNES_WRITE,
    input  logic [ADDR_W-1:0]     SNES_ADDR,
    input  logic                  SNES_WR_OK,
    input  logic [7:0]            SNES_DIN,
    output logic [7:0]            SNES_DOUT,
    output logic                  SNES_DONE,
    input  logic [NCH-1:0]        CH_REQ,
    input  logic [NCH-1:0]        CH_WE,
    input  logic [NCH*ADDR_W-1:0] CH_ADDR,
    input  logic [NCH*8-1:0]      CH_DIN,
    output logic [NCH-1:0]        CH_ACK,
    output logic [7:0]            CH_DOUT,
    output logic [ADDR_W-2:0]     MEM_ADDR,
    input  logic [15:0]           MEM_DQ_IN,
    output logic [15:0]           MEM_DQ_OUT,
    output logic                  MEM_DQ_OE,
    output logic                  MEM_WE_N,
    output logic                  MEM_OE_N,
    output logic                  MEM_BHE_N,
    output logic                  MEM_BLE_N,
    output logic                  BUSY
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNES_RD = 3'd1,
        ST_SNES_WR = 3'd2,
        ST_CH_RD   = 3'd3,
        ST_CH_WR   = 3'd4,
        ST_END     = 3'd5
    } state_t;

    // Odd byte addresses live on DQ[7:0], even ones on DQ[15:8].
    function automatic logic [7:0] lane_sel(input logic [15:0] dq, input logic a0);
        lane_sel = a0 ? dq[7:0] : dq[15:8];
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, wait_s;
    logic               cnt_zero_s;
    logic               snes_acc_s, ch_acc_s, access_s;
    logic               pend_r, pend_wr_r;
    logic               snes_wr_ok_r;
    logic               gnt_found_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               ch_take_s;
    logic [IDX_W-1:0]   ch_idx_r;
    logic [ADDR_W-1:0]  ch_addr_r;
    logic [7:0]         ch_din_r;
    logic               wr_en_s, is_wr_nxt_s;
    logic [NCH-1:0]     ch_ack_nxt_s;
    logic [NCH-1:0]     ch_ack_r;
    logic               snes_done_r;
    logic [7:0]         snes_dout_r, ch_dout_r;
    logic               mem_we_n_r, mem_dq_oe_r, mem_oe_n_r, busy_r;
    logic               acc_a0_s;
    logic [7:0]         wr_byte_s;
`ifdef PSRAM_ARB_RR_EN
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    int                 rr_j_s;
`endif

    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
    assign snes_acc_s = (state_r == ST_SNES_RD) || (state_r == ST_SNES_WR);
    assign ch_acc_s   = (state_r == ST_CH_RD) || (state_r == ST_CH_WR);
    assign access_s   = snes_acc_s || ch_acc_s;

`ifdef PSRAM_ARB_RR_EN
    // Round-robin grant: search from the pointer upward, wrapping at NCH-1
    always_comb begin
        gnt_found_s  = |CH_REQ;
        gnt_idx_s    = {IDX_W{1'b0}};
        rr_j_s       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            rr_j_s    = (int'(rr_ptr_r) + k) % NCH;
            gnt_idx_s = CH_REQ[rr_j_s] ? IDX_W'(rr_j_s) : gnt_idx_s;
        end
        rr_ptr_nxt_s = (gnt_idx_s == IDX_W'(NCH - 1)) ? {IDX_W{1'b0}} : (gnt_idx_s + IDX_W'(1));
    end
`else
    // Fixed-priority grant: lowest requesting index wins
    always_comb begin
        gnt_found_s = |CH_REQ;
        gnt_idx_s   = {IDX_W{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            gnt_idx_s = CH_REQ[i] ? IDX_W'(i) : gnt_idx_s;
        end
    end
`endif

    // Next-state, wait-counter load and write-enable decode
    always_comb begin
        state_nxt_s = state_r;
        ch_take_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (SNES_CYCLE_START) begin
                    state_nxt_s = SNES_WRITE ? ST_SNES_RD : ST_SNES_WR;
                end else if (gnt_found_s) begin
                    state_nxt_s = CH_WE[gnt_idx_s] ? ST_CH_WR : ST_CH_RD;
                    ch_take_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SNES_RD, ST_SNES_WR, ST_CH_RD, ST_CH_WR: begin
                state_nxt_s = cnt_zero_s ? ST_END : state_r;
            end
            ST_END: begin
                if (pend_r) begin
                    state_nxt_s = pend_wr_r ? ST_SNES_WR : ST_SNES_RD;
                end else if (SNES_CYCLE_START) begin
                    state_nxt_s = SNES_WRITE ? ST_SNES_RD : ST_SNES_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        case (state_nxt_s)
            ST_SNES_RD: wait_s = CNT_W'(SNES_RD_WAIT);
            ST_SNES_WR: wait_s = CNT_W'(SNES_WR_WAIT);
            ST_CH_RD:   wait_s = CNT_W'(CH_RD_WAIT);
            ST_CH_WR:   wait_s = CNT_W'(CH_WR_WAIT);
            default:    wait_s = {CNT_W{1'b0}};
        endcase
        cnt_nxt_s = access_s ? (cnt_r - CNT_W'(1)) : wait_s;

        // A disallowed SNES write still runs its timing, just without strobes.
        case (state_nxt_s)
            ST_CH_WR:   wr_en_s = 1'b1;
            ST_SNES_WR: wr_en_s = (state_r == ST_SNES_WR) ? snes_wr_ok_r : SNES_WR_OK;
            default:    wr_en_s = 1'b0;
        endcase
        is_wr_nxt_s = (state_nxt_s == ST_SNES_WR) || (state_nxt_s == ST_CH_WR);

        ch_ack_nxt_s           = {NCH{1'b0}};
        ch_ack_nxt_s[ch_idx_r] = ch_acc_s && cnt_zero_s;
    end

    // Memory address, byte lanes and write data follow the current owner
    always_comb begin
        if (ch_acc_s) begin
            MEM_ADDR  = ch_addr_r[ADDR_W-1:1];
            acc_a0_s  = ch_addr_r[0];
            wr_byte_s = ch_din_r;
        end else begin
            MEM_ADDR  = SNES_ADDR[ADDR_W-1:1];
            acc_a0_s  = SNES_ADDR[0];
            wr_byte_s = SNES_DIN;
        end
        MEM_BLE_N  = ~acc_a0_s;
        MEM_BHE_N  = acc_a0_s;
        MEM_DQ_OUT = {wr_byte_s, wr_byte_s};
    end

    // FSM state register and wait counter
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // SNES starts during a channel access collapse into one pending request
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            pend_r    <= 1'b0;
            pend_wr_r <= 1'b0;
        end else if (ch_acc_s && SNES_CYCLE_START) begin
            pend_r    <= 1'b1;
            pend_wr_r <= ~SNES_WRITE;
        end else if ((state_nxt_s == ST_SNES_RD) || (state_nxt_s == ST_SNES_WR)) begin
            pend_r    <= 1'b0;
        end
    end

    // Capture write permission and channel request details on access entry
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            snes_wr_ok_r <= 1'b0;
            ch_idx_r     <= {IDX_W{1'b0}};
            ch_addr_r    <= {ADDR_W{1'b0}};
            ch_din_r     <= 8'h00;
        end else begin
            if ((state_r != ST_SNES_WR) && (state_nxt_s == ST_SNES_WR)) begin
                snes_wr_ok_r <= SNES_WR_OK;
            end
            if (ch_take_s) begin
                ch_idx_r  <= gnt_idx_s;
                ch_addr_r <= CH_ADDR[int'(gnt_idx_s) * ADDR_W +: ADDR_W];
                ch_din_r  <= CH_DIN[int'(gnt_idx_s) * 8 +: 8];
            end
        end
    end

`ifdef PSRAM_ARB_RR_EN
    // Round-robin pointer moves past the channel just granted
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (ch_take_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end
`endif

    // Registered PSRAM strobes; output enable and OE_N hold through END
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            mem_we_n_r  <= 1'b1;
            mem_dq_oe_r <= 1'b0;
            mem_oe_n_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_we_n_r  <= ~wr_en_s;
            mem_dq_oe_r <= wr_en_s ? 1'b1 : ((state_nxt_s == ST_END) ? mem_dq_oe_r : 1'b0);
            mem_oe_n_r  <= is_wr_nxt_s ? 1'b1 : ((state_nxt_s == ST_END) ? mem_oe_n_r : 1'b0);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Completion pulses and read data captured on the last access cycle
    always_ff @(posedge CLK2 or negedge RST_N) begin
        if (!RST_N) begin
            snes_done_r <= 1'b0;
            ch_ack_r    <= {NCH{1'b0}};
            snes_dout_r <= 8'h00;
            ch_dout_r   <= 8'h00;
        end else begin
            snes_done_r <= snes_acc_s && cnt_zero_s;
            ch_ack_r    <= ch_ack_nxt_s;
            if ((state_r == ST_SNES_RD) && cnt_zero_s) begin
                snes_dout_r <= lane_sel(MEM_DQ_IN, SNES_ADDR[0]);
            end
            if ((state_r == ST_CH_RD) && cnt_zero_s) begin
                ch_dout_r <= lane_sel(MEM_DQ_IN, ch_addr_r[0]);
            end
        end
    end

    assign SNES_DOUT = snes_dout_r;
    assign SNES_DONE = snes_done_r;
    assign CH_ACK    = ch_ack_r;
    assign CH_DOUT   = ch_dout_r;
    assign MEM_WE_N  = mem_we_n_r;
    assign MEM_DQ_OE = mem_dq_oe_r;
    assign MEM_OE_N  = mem_oe_n_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: table-driven single-access vectors plus hand sequences
// for priority, pending SNES start, reset abort and multi-grant order.
// Completions are checked against a scoreboard of expected events.
module tb_psram_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 24;

    logic              CLK2 = 1'b0;
    logic              RST_N = 1'b0;
    logic              SNES_CYCLE_START = 1'b0;
    logic              SNES_WRITE = 1'b1;
    logic [AW-1:0]     SNES_ADDR = '0;
    logic              SNES_WR_OK = 1'b0;
    logic [7:0]        SNES_DIN = 8'h00;
    logic [7:0]        SNES_DOUT;
    logic              SNES_DONE;
    logic [NCH-1:0]    CH_REQ = '0;
    logic [NCH-1:0]    CH_WE = '0;
    logic [NCH*AW-1:0] CH_ADDR = '0;
    logic [NCH*8-1:0]  CH_DIN = '0;
    logic [NCH-1:0]    CH_ACK;
    logic [7:0]        CH_DOUT;
    logic [AW-2:0]     MEM_ADDR;
    logic [15:0]       MEM_DQ_IN = 16'h0000;
    logic [15:0]       MEM_DQ_OUT;
    logic              MEM_DQ_OE, MEM_WE_N, MEM_OE_N, MEM_BHE_N, MEM_BLE_N, BUSY;

    psram_arbiter dut (
        .CLK2(CLK2), .RST_N(RST_N),
        .SNES_CYCLE_START(SNES_CYCLE_START), .SNES_WRITE(SNES_WRITE),
        .SNES_ADDR(SNES_ADDR), .SNES_WR_OK(SNES_WR_OK), .SNES_DIN(SNES_DIN),
        .SNES_DOUT(SNES_DOUT), .SNES_DONE(SNES_DONE),
        .CH_REQ(CH_REQ), .CH_WE(CH_WE), .CH_ADDR(CH_ADDR), .CH_DIN(CH_DIN),
        .CH_ACK(CH_ACK), .CH_DOUT(CH_DOUT),
        .MEM_ADDR(MEM_ADDR), .MEM_DQ_IN(MEM_DQ_IN), .MEM_DQ_OUT(MEM_DQ_OUT),
        .MEM_DQ_OE(MEM_DQ_OE), .MEM_WE_N(MEM_WE_N), .MEM_OE_N(MEM_OE_N),
        .MEM_BHE_N(MEM_BHE_N), .MEM_BLE_N(MEM_BLE_N), .BUSY(BUSY)
    );

    always #5 CLK2 = ~CLK2;

    typedef struct {
        bit          is_ch;
        int          ch;
        logic [7:0]  data;
        bit          chk_data;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          is_ch;
        int          ch;
        bit          we;
        logic [23:0] addr;
        logic [7:0]  din;
        logic [15:0] dq;
        bit          wr_ok;
        logic [7:0]  exp_data;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK2);
        #2;
    endtask

    // Completion monitor: every DONE/ACK pulse must match the scoreboard head
    initial begin
        exp_t e;
        logic [NCH:0] got, want;
        forever begin
            @(posedge CLK2);
            #1;
            cyc = cyc + 1;
            if (SNES_DONE === 1'b1 || CH_ACK !== '0) begin
                got = {SNES_DONE, CH_ACK};
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(got), 32'h0);
                end else begin
                    e = sb.pop_front();
                    want = e.is_ch ? {1'b0, NCH'(1) << e.ch} : {1'b1, {NCH{1'b0}}};
                    chk("sb_who", 32'(got), 32'(want));
                    chk("sb_cycle", cyc, e.cyc);
                    if (e.chk_data) chk("sb_data", e.is_ch ? CH_DOUT : SNES_DOUT, e.data);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bit   en;
        exp_t e;
        en = v.we && (v.is_ch || v.wr_ok);
        MEM_DQ_IN = v.dq;
        if (v.is_ch) begin
            SNES_ADDR = 24'hFFFFFE;
            CH_ADDR = '0; CH_ADDR[v.ch*AW +: AW] = v.addr;
            CH_DIN  = '0; CH_DIN[v.ch*8 +: 8] = v.din;
            CH_WE   = '0; CH_WE[v.ch] = v.we;
            CH_REQ  = '0; CH_REQ[v.ch] = 1'b1;
        end else begin
            SNES_ADDR = v.addr; SNES_WRITE = !v.we; SNES_DIN = v.din;
            SNES_WR_OK = v.wr_ok; SNES_CYCLE_START = 1'b1;
        end
        e = '{v.is_ch, v.ch, v.exp_data, !v.we, cyc + v.lat};
        sb.push_back(e);
        tick();
        SNES_CYCLE_START = 1'b0;
        for (int c = 1; c <= v.lat + 1; c++) begin
            if (c < v.lat) begin
                chk("acc_we_n", MEM_WE_N, !en);
                chk("acc_dq_oe", MEM_DQ_OE, en);
                chk("acc_oe_n", MEM_OE_N, v.we);
                chk("acc_busy", BUSY, 1'b1);
                chk("acc_addr", MEM_ADDR, v.addr[23:1]);
                chk("acc_ble_n", MEM_BLE_N, !v.addr[0]);
                chk("acc_bhe_n", MEM_BHE_N, v.addr[0]);
                if (v.we) chk("acc_dq_out", MEM_DQ_OUT, {v.din, v.din});
            end else if (c == v.lat) begin
                chk("end_we_n", MEM_WE_N, 1'b1);
                chk("end_dq_oe", MEM_DQ_OE, en);
                chk("end_busy", BUSY, 1'b1);
                CH_REQ = '0;
            end else begin
                chk("idle_busy", BUSY, 1'b0);
                chk("idle_dq_oe", MEM_DQ_OE, 1'b0);
            end
            if (c <= v.lat) tick();
        end
    endtask

    initial begin
        vec_t vt[8];
        int   c0;
        int   gch;

        vt[0] = '{1'b0, 0, 1'b0, 24'h000001, 8'h00, 16'hA55A, 1'b1, 8'h5A, 6};
        vt[1] = '{1'b0, 0, 1'b0, 24'h000002, 8'h00, 16'hA55A, 1'b1, 8'hA5, 6};
        vt[2] = '{1'b0, 0, 1'b1, 24'h000010, 8'h3C, 16'h0000, 1'b1, 8'h00, 7};
        vt[3] = '{1'b0, 0, 1'b1, 24'h000011, 8'h77, 16'h0000, 1'b0, 8'h00, 7};
        vt[4] = '{1'b1, 0, 1'b0, 24'h123457, 8'h00, 16'h1234, 1'b1, 8'h34, 8};
        vt[5] = '{1'b1, 1, 1'b0, 24'h00ABC0, 8'h00, 16'hBEEF, 1'b1, 8'hBE, 8};
        vt[6] = '{1'b1, 1, 1'b1, 24'h000003, 8'h99, 16'h0000, 1'b1, 8'h00, 8};
        vt[7] = '{1'b1, 0, 1'b1, 24'h000004, 8'h42, 16'h0000, 1'b1, 8'h00, 8};

        // Reset state
        tick(); tick();
        chk("rst_snes_dout", SNES_DOUT, 8'h00);
        chk("rst_ch_dout", CH_DOUT, 8'h00);
        chk("rst_done", SNES_DONE, 1'b0);
        chk("rst_ack", CH_ACK, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_we_n", MEM_WE_N, 1'b1);
        chk("rst_dq_oe", MEM_DQ_OE, 1'b0);
        chk("rst_oe_n", MEM_OE_N, 1'b0);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // SNES start and channel 0 request in the same cycle: SNES first
        MEM_DQ_IN = 16'h1122;
        SNES_ADDR = 24'h000002; SNES_WRITE = 1'b1; SNES_CYCLE_START = 1'b1;
        CH_ADDR = '0; CH_ADDR[23:0] = 24'h000005; CH_WE = 2'b00; CH_REQ = 2'b01;
        c0 = cyc;
        sb.push_back('{1'b0, 0, 8'h11, 1'b1, c0 + 6});
        sb.push_back('{1'b1, 0, 8'h22, 1'b1, c0 + 15});
        tick();
        SNES_CYCLE_START = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 1) chk("prio_snes_addr", MEM_ADDR, 23'h000001);
            if (c == 7) chk("prio_idle_gap", BUSY, 1'b0);
            if (c == 8) chk("prio_ch_addr", MEM_ADDR, 23'h000002);
            if (c == 15) CH_REQ = 2'b00;
            tick();
        end

        // Channel 1 write with SNES starts at cycles 2 and 4 (collapse to one)
        SNES_ADDR = 24'h000003; SNES_WRITE = 1'b1; MEM_DQ_IN = 16'hCAFE;
        CH_ADDR = '0; CH_ADDR[47:24] = 24'h000021;
        CH_DIN = '0; CH_DIN[15:8] = 8'h55; CH_WE = 2'b10; CH_REQ = 2'b10;
        c0 = cyc;
        sb.push_back('{1'b1, 1, 8'h00, 1'b0, c0 + 8});
        sb.push_back('{1'b0, 0, 8'hFE, 1'b1, c0 + 14});
        tick();
        for (int c = 1; c <= 15; c++) begin
            SNES_CYCLE_START = (c == 2 || c == 4);
            if (c == 3) begin
                chk("pend_we_n", MEM_WE_N, 1'b0);
                chk("pend_ch_addr", MEM_ADDR, 23'h000010);
                chk("pend_dq_out", MEM_DQ_OUT, 16'h5555);
            end
            if (c == 8) begin
                chk("pend_end_dq_oe", MEM_DQ_OE, 1'b1);
                CH_REQ = 2'b00;
            end
            if (c == 9) begin
                chk("pend_no_idle", BUSY, 1'b1);
                chk("pend_dq_oe_off", MEM_DQ_OE, 1'b0);
                chk("pend_snes_addr", MEM_ADDR, 23'h000001);
            end
            if (c == 15) chk("pend_idle", BUSY, 1'b0);
            tick();
        end
        SNES_CYCLE_START = 1'b0;

        // Reset in the middle of a channel write aborts it
        CH_ADDR = '0; CH_ADDR[23:0] = 24'h000040;
        CH_DIN = '0; CH_DIN[7:0] = 8'h11; CH_WE = 2'b01; CH_REQ = 2'b01;
        tick(); tick(); tick();
        chk("abort_pre_we_n", MEM_WE_N, 1'b0);
        chk("abort_pre_busy", BUSY, 1'b1);
        RST_N = 1'b0; CH_REQ = 2'b00;
        #1;
        chk("abort_we_n", MEM_WE_N, 1'b1);
        chk("abort_dq_oe", MEM_DQ_OE, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_ack", CH_ACK, 2'b00);
        chk("abort_snes_dout", SNES_DOUT, 8'h00);
        chk("abort_ch_dout", CH_DOUT, 8'h00);
        tick(); tick();
        RST_N = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("abort_stay_idle", BUSY, 1'b0);

        // Both channels held for four grants
        CH_ADDR = {24'h000200, 24'h000101}; CH_WE = 2'b00; MEM_DQ_IN = 16'h6789;
        CH_REQ = 2'b11;
        c0 = cyc;
        for (int g = 0; g < 4; g++) begin
`ifdef PSRAM_ARB_RR_EN
            gch = g % 2;
`else
            gch = 0;
`endif
            sb.push_back('{1'b1, gch, (gch == 0) ? 8'h89 : 8'h67, 1'b1, c0 + 8 + 9 * g});
        end
        for (int c = 1; c <= 35; c++) tick();
        CH_REQ = 2'b00;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick(); tick();
        chk("sb_drain", sb.size(), 0);
        chk("final_idle", BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Parametrised PSRAM access arbiter and sequencer for the 16-bit ROM bus. It serves SNES bus cycles with absolute priority and arbitrates NCH secondary requestors (MCU, SD DMA, ...) with a request/acknowledge handshake. It runs configurable wait-state counts and drives byte lanes for 8-bit transfers on the 16-bit device. It sits between the address mapper / SPI command front end and the PSRAM pins, and supersedes the hard-wired single-MCU state machine in the top level.

## Interface
- NCH, 2: number of secondary requestor channels (1..8)
- ADDR_W, 24: byte address width
- SNES_RD_WAIT, 4: SNES read access cycles minus one
- SNES_WR_WAIT, 5: SNES write access cycles minus one
- CH_RD_WAIT, 6: channel read access cycles minus one
- CH_WR_WAIT, 6: channel write access cycles minus one

Ports:
- CLK2  in  1  system clock (DCM output)
- RST_N  in  1  asynchronous active-low reset
- SNES_CYCLE_START  in  1  one-cycle pulse, SNES bus cycle begins
- SNES_WRITE  in  1  active-low write strobe, sampled with SNES_CYCLE_START
- SNES_ADDR  in  ADDR_W  mapped SNES byte address
- SNES_WR_OK  in  1  write permitted (save RAM region)
- SNES_DIN  in  8  SNES write data, sampled on last access cycle
- SNES_DOUT  out  8  registered SNES read data
- SNES_DONE  out  1  one-cycle pulse, SNES access complete
- CH_REQ  in  NCH  per-channel level request
- CH_WE  in  NCH  per-channel write (1) / read (0)
- CH_ADDR  in  NCH*ADDR_W  packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
- CH_DIN  in  NCH*8  packed channel write data
- CH_ACK  out  NCH  one-cycle completion pulse to the granted channel
- CH_DOUT  out  8  channel read data, valid while CH_ACK high and held until next channel read
- MEM_ADDR  out  ADDR_W-1  PSRAM word address
- MEM_DQ_IN  in  16  PSRAM data in
- MEM_DQ_OUT  out  16  PSRAM data out (byte replicated on both lanes)
- MEM_DQ_OE  out  1  data output enable
- MEM_WE_N, MEM_OE_N, MEM_BHE_N, MEM_BLE_N  out  1 each  PSRAM strobes
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SNES_RD, SNES_WR, CH_RD, CH_WR, END.
- IDLE:
  - SNES_CYCLE_START selects SNES_WR if SNES_WRITE=0, else SNES_RD.
  - Otherwise any CH_REQ selects CH_WR/CH_RD for the granted channel; address, data and channel index are latched.
- SNES start beats any channel request in the same cycle.
- Access state: the wait counter loads the matching WAIT on entry and decrements every cycle. At counter 0:
  - reads register the selected lane into SNES_DOUT or CH_DOUT;
  - writes release MEM_WE_N.
  - Then go to END.
- END lasts one cycle: pulse SNES_DONE or CH_ACK[granted], drop MEM_DQ_OE.
  - Next state is SNES_RD/SNES_WR if an SNES start is pending, else IDLE.
- SNES start arriving during a channel access sets a pending flag (with write/read captured). Further starts before it is served collapse into one. A start during an SNES access is ignored.
- Address mux:
  - IDLE and SNES states: MEM_ADDR = SNES_ADDR[ADDR_W-1:1].
  - Channel states: latched channel address.
- Byte lanes: address bit 0 = 1 uses DQ[7:0] (MEM_BLE_N=0, MEM_BHE_N=1); bit 0 = 0 uses DQ[15:8].
- Writes:
  - MEM_WE_N=0 and MEM_DQ_OE=1 from access entry. MEM_WE_N returns to 1 at exit; MEM_DQ_OE stays 1 through END.
  - MEM_OE_N=1 during writes, 0 otherwise.
  - SNES write with SNES_WR_OK=0 runs the full timing with MEM_WE_N and MEM_DQ_OE held inactive; SNES_DONE still pulses.
- Channel handshake:
  - CH_REQ is held until CH_ACK.
  - Deasserting CH_REQ early does not abort; the access completes and CH_ACK pulses.
  - A channel re-requesting in the ACK cycle is eligible the next IDLE.
- Reset values:
  - state IDLE, pending 0, grant pointer 0;
  - SNES_DOUT=0, CH_DOUT=0, SNES_DONE=0, CH_ACK=0, BUSY=0;
  - MEM_WE_N=1, MEM_DQ_OE=0, MEM_OE_N=0.
- Reset mid-access aborts with no ACK/DONE; requestors re-present.

## Timing
- Request seen in IDLE at cycle 0: access occupies cycles 1..WAIT+1, END at cycle WAIT+2, ACK/DONE high in that cycle.
- Channel read latency = CH_RD_WAIT+2 cycles (8 at default).
- SNES read latency = SNES_RD_WAIT+2 cycles (6 at default).
- Worst-case SNES delay behind a channel write = CH_WR_WAIT+2 cycles.
- Integrator guarantees the SNES cycle period exceeds SNES service plus the worst channel access.

## Configuration
- PSRAM_ARB_RR_EN defined: round-robin grant. Search starts at the channel after the last granted one and wraps NCH-1 to 0; the pointer updates on grant.
- Not defined: fixed priority, lowest index wins; the pointer is unused.

## Test plan
- SNES read, addr 0x000001, MEM_DQ_IN=0xA55A -> SNES_DOUT=0x5A, SNES_DONE at cycle 6, MEM_BLE_N=0.
- SNES write 0x3C to 0x000010, SNES_WR_OK=1 -> MEM_WE_N low cycles 1..6, MEM_DQ_OUT[15:8]=0x3C; SNES_WR_OK=0 -> MEM_WE_N stays 1, DONE at cycle 7.
- CH_REQ[0] and SNES_CYCLE_START same cycle -> SNES served first, CH_ACK[0] follows after SNES END.
- Channel 1 write in progress plus SNES start at cycle 2 -> CH_ACK[1] at cycle 8, SNES access starts at cycle 9 with no IDLE cycle between.
- CH_REQ=2'b11 held for 4 grants -> with PSRAM_ARB_RR_EN grants 0,1,0,1; without it grants 0,0,0,0.
- RST_N low during CH_WR -> MEM_WE_N=1 and MEM_DQ_OE=0 immediately, no CH_ACK, BUSY=0.
